// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control bundle, writeback-select encodings and bubble constant for pipeline registers
package pipe_pkg;
  localparam int RES_W = 2;
  typedef enum logic [RES_W-1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } res_src_e;
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic [RES_W-1:0] result_src;
    logic [2:0]       funct3;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: event counter that sticks at all-ones instead of wrapping
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_ex_mem.sv
// pipe_ex_mem: EX->MEM stage register with stall/flush, forwarding tap and stall/flush event counters
module pipe_ex_mem
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int RS_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_m,
  input  logic             flush_m,
  input  logic             valid_e,
  input  logic             reg_write_e,
  input  logic             mem_write_e,
  input  logic [RS_W-1:0]  result_src_e,
  input  logic [2:0]       funct3_e,
  input  logic [XLEN-1:0]  alu_result_e,
  input  logic [XLEN-1:0]  write_data_e,
  input  logic [XLEN-1:0]  pc_plus_4_e,
  input  logic [RA_W-1:0]  rd_e,
  output logic             valid_m,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [RS_W-1:0]  result_src_m,
  output logic [2:0]       funct3_m,
  output logic [XLEN-1:0]  alu_result_m,
  output logic [XLEN-1:0]  write_data_m,
  output logic [XLEN-1:0]  pc_plus_4_m,
  output logic [RA_W-1:0]  rd_m,
  output logic             fwd_en_m,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  ctrl_t ctrl_d, ctrl_q;
  // a slot that is not valid must never be able to write regfile or memory
  assign ctrl_d = '{reg_write: reg_write_e & valid_e, mem_write: mem_write_e & valid_e,
                    result_src: result_src_e, funct3: funct3_e};
  always_ff @(posedge clk)
    if (reset || flush_m) begin
      valid_m      <= 1'b0;
      ctrl_q       <= CTRL_BUBBLE;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus_4_m  <= '0;
      rd_m         <= '0;
    end else if (!stall_m) begin
      valid_m      <= valid_e;
      ctrl_q       <= ctrl_d;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      pc_plus_4_m  <= pc_plus_4_e;
      rd_m         <= rd_e;
    end
  assign reg_write_m  = ctrl_q.reg_write;
  assign mem_write_m  = ctrl_q.mem_write;
  assign result_src_m = ctrl_q.result_src;
  assign funct3_m     = ctrl_q.funct3;
  assign fwd_en_m     = valid_m & reg_write_m & (rd_m != '0);
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .clear(reset), .inc(stall_m & ~flush_m), .count(stall_cnt)
  );
  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .clear(reset), .inc(flush_m), .count(flush_cnt)
  );
endmodule

// File: doc/pipe_ex_mem.md
# pipe_ex_mem

Parametrised EX→MEM pipeline register for the RISC-V core, between the execute stage (ALU, branch resolution) and the memory stage. It carries full-width datapath fields plus the memory/writeback control bundle and a valid bit. It supports stall (hold) and flush (bubble insertion) from the hazard unit, and exports a forwarding tap and saturating stall/flush event counters for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width of alu_result, write_data, pc_plus_4.
- RA_W, 5, register-address width of rd.
- RS_W, 2, width of the result_src select.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high; sampled only on rising clk.
- stall_m  in  1  hold all stage contents this cycle.
- flush_m  in  1  load a bubble this cycle; has priority over stall_m.
- valid_e  in  1  execute-stage instruction is valid.
- reg_write_e  in  1  instruction writes the register file.
- mem_write_e  in  1  instruction stores to memory.
- result_src_e  in  RS_W  writeback select: 0 = ALU, 1 = memory, 2 = PC+4.
- funct3_e  in  3  load/store size and sign.
- alu_result_e, write_data_e, pc_plus_4_e  in  XLEN  datapath fields.
- rd_e  in  RA_W  destination register.
- valid_m, reg_write_m, mem_write_m, result_src_m, funct3_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m  out  same widths  registered copies.
- fwd_en_m  out  1  forwarding source is live: valid_m & reg_write_m & (rd_m != 0).
- stall_cnt  out  CNT_W  saturating count of cycles that held a stall.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

## Operation
- Each rising clk, in priority order: reset > flush_m > stall_m > load.
- reset: every registered output and both counters go to 0.
- flush_m=1: valid_m, reg_write_m, mem_write_m go to 0. All other fields go to 0, so rd_m=0 and result_src_m=0. flush_cnt increments. stall_cnt is unchanged even if stall_m=1.
- stall_m=1, flush_m=0: all fields hold their values and stall_cnt increments.
- load (neither asserted): all fields capture their _e inputs. Control sanitising: if valid_e=0, reg_write_m and mem_write_m load 0 regardless of their inputs, so a non-valid slot can never write. Data fields still capture.
- Counters saturate at 2^CNT_W−1 and never wrap. They change only on the conditions above.
- fwd_en_m is combinational from registered outputs only; there is no path from any _e input.

## Timing
- Latency is 1 cycle: an input loaded at edge N appears on the _m outputs after edge N.
- Reset is synchronous: asserting reset between edges has no effect until the next edge. Reset mid-stall or mid-flush clears everything at that edge.
- Outputs are glitch-free registered values, except fwd_en_m, which is a single AND/compare level after the registers.
- stall_m held for K consecutive cycles keeps the outputs frozen for K cycles and adds K to stall_cnt.
- stall_m and flush_m asserted together: flush wins; bubble loaded; only flush_cnt increments.

## Structure
- Shared package pipe_pkg holds:
  - ctrl_t packed struct {reg_write, mem_write, result_src[RS_W], funct3[3]};
  - result_src encodings RES_ALU=0, RES_MEM=1, RES_PC4=2;
  - CTRL_BUBBLE constant (all zero).
- The stage register itself stores ctrl_t plus the data fields.
- Sub-module: pipe_sat_counter (CNT_W, inc, clear → count), instantiated twice (stall, flush).

## Test plan
- Reset: drive arbitrary inputs with reset=1 for 2 cycles → all outputs 0, stall_cnt=flush_cnt=0, fwd_en_m=0.
- Load: valid_e=1, reg_write_e=1, rd_e=5, alu_result_e=0xDEADBEEF, pc_plus_4_e=0x104 → next cycle outputs match, fwd_en_m=1.
- Stall: after loading rd=5, hold stall_m=1 for 3 cycles while inputs change → _m outputs unchanged, stall_cnt=3.
- Flush vs stall: stall_m=flush_m=1 on a loaded stage → valid_m=0, rd_m=0, reg_write_m=0, fwd_en_m=0, flush_cnt=1, stall_cnt unchanged.
- Sanitising and x0: valid_e=0 with reg_write_e=mem_write_e=1 → both _m=0. Then valid_e=1, reg_write_e=1, rd_e=0 → fwd_en_m=0.
- Saturation: CNT_W=4, stall 20 cycles → stall_cnt=15 and stays 15.
